video_mode_ctrl: RTL and testbench

//   Configuration sequencer for video_mixer. Accepts mode writes (scanlines, scandoubler

---
 rtl/video_mode_ctrl.sv | 135 +++++++++++++
 tb/tb_video_mode_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_mode_ctrl.sv
// Mode-configuration sequencer for video_mixer: shadows mode writes and commits them
// on frame boundaries, blanking the picture for a few frames after structural changes.
module video_mode_ctrl #(
    parameter logic [6:0]  INIT_CFG     = 7'h00,
    parameter logic [3:0]  BLANK_FRAMES = 4'd2,
    parameter logic [20:0] TIMEOUT      = 21'h100000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [6:0] cfg_data,
    input  logic       VSync,
    output logic [1:0] scanlines,
    output logic       scandoubler_disable,
    output logic       hq2x,
    output logic       ypbpr,
    output logic       ypbpr_full,
    output logic       mono,
    output logic       blank,
    output logic       cfg_pending
);

    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_BLANK} state_t;

    state_t      state_q, state_d;
    logic [6:0]  active_q, active_d;
    logic [6:0]  pending_q, pending_d;
    logic        blank_q, blank_d;
    logic        cfg_pending_q, cfg_pending_d;
    logic        vs_dly_q, vs_dly_d;
    logic [20:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]  frm_cnt_q, frm_cnt_d;
    logic        frame_tick;
    logic        accept;
    logic        structural;

    assign cfg_ready  = reset_n && (state_q != S_BLANK);
    assign accept     = cfg_valid && cfg_ready;
    assign frame_tick = (vs_dly_q && !VSync) || (tmo_cnt_q == TIMEOUT - 21'd1);
    // Only scandoubler bypass and YPbPr change the sync structure seen by the monitor.
    assign structural = (pending_q[2] != active_q[2]) || (pending_q[4] != active_q[4]);

    always_comb begin
        state_d       = state_q;
        active_d      = active_q;
        pending_d     = pending_q;
        blank_d       = blank_q;
        cfg_pending_d = cfg_pending_q;
        frm_cnt_d     = frm_cnt_q;
        vs_dly_d      = VSync;

        if (frame_tick || state_q == S_IDLE) begin
            tmo_cnt_d = 21'd0;
        end else if (tmo_cnt_q == TIMEOUT - 21'd1) begin
            tmo_cnt_d = tmo_cnt_q;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 21'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pending_d     = cfg_data;
                    cfg_pending_d = 1'b1;
                    state_d       = S_PENDING;
                end
            end
            S_PENDING: begin
                if (frame_tick) begin
                    active_d      = pending_q;
                    cfg_pending_d = accept;
                    if (accept) begin
                        pending_d = cfg_data;
                    end
                    // A write landing on a structural commit is kept and committed after blanking.
                    if (structural && BLANK_FRAMES != 4'd0) begin
                        state_d   = S_BLANK;
                        blank_d   = 1'b1;
                        frm_cnt_d = 4'd0;
                    end else if (!accept) begin
                        state_d = S_IDLE;
                    end
                end else if (accept) begin
                    pending_d = cfg_data;
                end
            end
            S_BLANK: begin
                if (frame_tick) begin
                    if (frm_cnt_q == BLANK_FRAMES - 4'd1) begin
                        blank_d = 1'b0;
                        state_d = cfg_pending_q ? S_PENDING : S_IDLE;
                    end else begin
                        frm_cnt_d = frm_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            active_q      <= INIT_CFG;
            pending_q     <= INIT_CFG;
            blank_q       <= 1'b0;
            cfg_pending_q <= 1'b0;
            vs_dly_q      <= 1'b0;
            tmo_cnt_q     <= 21'd0;
            frm_cnt_q     <= 4'd0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            blank_q       <= blank_d;
            cfg_pending_q <= cfg_pending_d;
            vs_dly_q      <= vs_dly_d;
            tmo_cnt_q     <= tmo_cnt_d;
            frm_cnt_q     <= frm_cnt_d;
        end
    end

    assign scanlines           = active_q[1:0];
    assign scandoubler_disable = active_q[2];
    assign hq2x                = active_q[3];
    assign ypbpr               = active_q[4];
    assign ypbpr_full          = active_q[5];
    assign mono                = active_q[6];
    assign blank               = blank_q;
    assign cfg_pending         = cfg_pending_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Bench for video_mode_ctrl: two instances (long and 16-cycle timeout) share stimulus and are
// checked by directed scenarios and a randomized run against a frame-level reference model.
module tb_video_mode_ctrl;

    logic       clk_sys;
    logic       reset_n;
    logic       cfg_valid;
    logic [6:0] cfg_data;
    logic       VSync;

    logic [6:0] cfg0, cfg1;
    logic       rdy0, rdy1, blk0, blk1, pnd0, pnd1;

    int n_cmp  = 0;
    int n_fail = 0;

    video_mode_ctrl #(.INIT_CFG(7'h00), .BLANK_FRAMES(4'd2), .TIMEOUT(21'h100000)) u_big (
        .clk_sys(clk_sys), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(rdy0),
        .cfg_data(cfg_data), .VSync(VSync), .scanlines(cfg0[1:0]),
        .scandoubler_disable(cfg0[2]), .hq2x(cfg0[3]), .ypbpr(cfg0[4]),
        .ypbpr_full(cfg0[5]), .mono(cfg0[6]), .blank(blk0), .cfg_pending(pnd0)
    );

    video_mode_ctrl #(.INIT_CFG(7'h00), .BLANK_FRAMES(4'd2), .TIMEOUT(21'd16)) u_tmo (
        .clk_sys(clk_sys), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(rdy1),
        .cfg_data(cfg_data), .VSync(VSync), .scanlines(cfg1[1:0]),
        .scandoubler_disable(cfg1[2]), .hq2x(cfg1[3]), .ypbpr(cfg1[4]),
        .ypbpr_full(cfg1[5]), .mono(cfg1[6]), .blank(blk1), .cfg_pending(pnd1)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Reference model: frames-left-to-blank countdown, cycles since the last frame event.
    localparam int BLANK_N = 2;
    int         m_tmo[2]   = '{32'h100000, 16};
    logic [6:0] m_act[2]   = '{7'h00, 7'h00};
    logic [6:0] m_pend[2]  = '{7'h00, 7'h00};
    bit         m_has[2]   = '{1'b0, 1'b0};
    int         m_blk[2]   = '{0, 0};
    int         m_since[2] = '{0, 0};
    bit         m_vsp[2]   = '{1'b0, 1'b0};

    function automatic logic [9:0] dut_word(int k);
        if (k == 0) return {rdy0, pnd0, blk0, cfg0};
        return {rdy1, pnd1, blk1, cfg1};
    endfunction

    function automatic logic [9:0] mdl_word(int k);
        logic rdy;
        rdy = reset_n && (m_blk[k] == 0);
        return {rdy, m_has[k], (m_blk[k] != 0), m_act[k]};
    endfunction

    task automatic step();
        @(posedge clk_sys);
        for (int k = 0; k < 2; k++) begin
            bit tick, acc, idle;
            if (!reset_n) begin
                m_act[k] = 7'h00; m_pend[k] = 7'h00; m_has[k] = 1'b0;
                m_blk[k] = 0; m_since[k] = 0; m_vsp[k] = 1'b0;
            end else begin
                tick = (m_vsp[k] && !VSync) || (m_since[k] == m_tmo[k] - 1);
                acc  = cfg_valid && (m_blk[k] == 0);
                idle = !m_has[k] && (m_blk[k] == 0);
                if (tick || idle) m_since[k] = 0;
                else if (m_since[k] < m_tmo[k] - 1) m_since[k] = m_since[k] + 1;
                if (m_blk[k] > 0) begin
                    if (tick) m_blk[k] = m_blk[k] - 1;
                end else if (m_has[k] && tick) begin
                    if (m_pend[k][2] != m_act[k][2] || m_pend[k][4] != m_act[k][4])
                        m_blk[k] = BLANK_N;
                    m_act[k] = m_pend[k];
                    m_has[k] = acc;
                    if (acc) m_pend[k] = cfg_data;
                end else if (acc) begin
                    m_pend[k] = cfg_data;
                    m_has[k]  = 1'b1;
                end
                m_vsp[k] = VSync;
            end
        end
        #1;
    endtask

    task automatic frame_fall();
        VSync = 1'b1; step();
        VSync = 1'b0; step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cfg_valid = 1'b0; cfg_data = 7'h00; VSync = 1'b0;
        repeat (3) step();
        n_cmp++; if (cfg0 !== 7'h00) begin n_fail++; $display("FAIL rst_cfg got %h exp 00", cfg0); end
        n_cmp++; if ({rdy0, pnd0, blk0} !== 3'b000) begin n_fail++; $display("FAIL rst_ctl got %b exp 000", {rdy0, pnd0, blk0}); end
        n_cmp++; if (dut_word(1) !== mdl_word(1)) begin n_fail++; $display("FAIL rst_tmo got %h exp %h", dut_word(1), mdl_word(1)); end
        reset_n = 1'b1; #1;
        n_cmp++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", rdy0); end
    endtask

    task automatic test_scanlines();
        cfg_data = 7'h02; cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
        n_cmp++; if ({pnd0, cfg0} !== {1'b1, 7'h00}) begin n_fail++; $display("FAIL t1_accept got %b/%h exp 1/00", pnd0, cfg0); end
        repeat (94) step();
        VSync = 1'b1; repeat (5) step();
        n_cmp++; if (cfg0 !== 7'h00) begin n_fail++; $display("FAIL t1_early got %h exp 00", cfg0); end
        VSync = 1'b0; step();
        n_cmp++; if ({cfg0, blk0, pnd0} !== {7'h02, 1'b0, 1'b0}) begin n_fail++; $display("FAIL t1_commit got %h/%b/%b exp 02/0/0", cfg0, blk0, pnd0); end
        n_cmp++; if (dut_word(1) !== mdl_word(1)) begin n_fail++; $display("FAIL t1_tmo got %h exp %h", dut_word(1), mdl_word(1)); end
    endtask

    task automatic test_blank();
        cfg_data = 7'h06; cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
        frame_fall();
        n_cmp++; if ({cfg0, blk0, rdy0} !== {7'h06, 1'b1, 1'b0}) begin n_fail++; $display("FAIL t2_fall1 got %h/%b/%b exp 06/1/0", cfg0, blk0, rdy0); end
        cfg_data = 7'h06; cfg_valid = 1'b1;
        repeat (6) step();
        n_cmp++; if ({pnd0, blk0} !== 2'b01) begin n_fail++; $display("FAIL t2_hold got %b exp 01", {pnd0, blk0}); end
        frame_fall();
        n_cmp++; if (blk0 !== 1'b1) begin n_fail++; $display("FAIL t2_fall2 got %b exp 1", blk0); end
        repeat (5) step();
        frame_fall();
        n_cmp++; if ({blk0, rdy0, pnd0} !== 3'b010) begin n_fail++; $display("FAIL t2_fall3 got %b exp 010", {blk0, rdy0, pnd0}); end
        step(); cfg_valid = 1'b0;
        n_cmp++; if (pnd0 !== 1'b1) begin n_fail++; $display("FAIL t2_late_accept got %b exp 1", pnd0); end
        repeat (3) step();
        frame_fall();
        n_cmp++; if ({cfg0, blk0, pnd0} !== {7'h06, 1'b0, 1'b0}) begin n_fail++; $display("FAIL t2_same got %h/%b/%b exp 06/0/0", cfg0, blk0, pnd0); end
    endtask

    task automatic test_last_wins();
        int hq_seen = 0;
        cfg_data = 7'h0E; cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin step(); hq_seen += cfg0[3]; end
        cfg_data = 7'h46; cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
        hq_seen += cfg0[3];
        VSync = 1'b1; step(); hq_seen += cfg0[3];
        VSync = 1'b0; step(); hq_seen += cfg0[3];
        for (int i = 0; i < 4; i++) begin step(); hq_seen += cfg0[3]; end
        n_cmp++; if (hq_seen !== 0) begin n_fail++; $display("FAIL t3_hq2x_pulse got %0d exp 0", hq_seen); end
        n_cmp++; if ({cfg0, blk0, pnd0} !== {7'h46, 1'b0, 1'b0}) begin n_fail++; $display("FAIL t3_commit got %h/%b/%b exp 46/0/0", cfg0, blk0, pnd0); end
    endtask

    task automatic test_coincident();
        int pnd_low = 0;
        cfg_data = 7'h47; cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
        VSync = 1'b1; step();
        VSync = 1'b0; cfg_data = 7'h45; cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
        n_cmp++; if ({cfg0, pnd0} !== {7'h47, 1'b1}) begin n_fail++; $display("FAIL t4_first got %h/%b exp 47/1", cfg0, pnd0); end
        for (int i = 0; i < 4; i++) begin step(); pnd_low += !pnd0; end
        n_cmp++; if (pnd_low !== 0) begin n_fail++; $display("FAIL t4_pend_gap got %0d exp 0", pnd_low); end
        frame_fall();
        n_cmp++; if ({cfg0, pnd0} !== {7'h45, 1'b0}) begin n_fail++; $display("FAIL t4_second got %h/%b exp 45/0", cfg0, pnd0); end
    endtask

    task automatic test_timeout();
        VSync = 1'b0;
        cfg_data = 7'h55; cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
        repeat (15) step();
        n_cmp++; if (cfg1 !== 7'h45) begin n_fail++; $display("FAIL t5_early got %h exp 45", cfg1); end
        step();
        n_cmp++; if ({cfg1, blk1} !== {7'h55, 1'b1}) begin n_fail++; $display("FAIL t5_commit got %h/%b exp 55/1", cfg1, blk1); end
        repeat (31) step();
        n_cmp++; if (blk1 !== 1'b1) begin n_fail++; $display("FAIL t5_blank_hold got %b exp 1", blk1); end
        step();
        n_cmp++; if ({blk1, rdy1} !== 2'b01) begin n_fail++; $display("FAIL t5_blank_end got %b exp 01", {blk1, rdy1}); end
        n_cmp++; if ({cfg0, pnd0} !== {7'h45, 1'b1}) begin n_fail++; $display("FAIL t5_big_wait got %h/%b exp 45/1", cfg0, pnd0); end
    endtask

    task automatic test_reset_blank();
        frame_fall();
        n_cmp++; if ({cfg0, blk0} !== {7'h55, 1'b1}) begin n_fail++; $display("FAIL t6_enter got %h/%b exp 55/1", cfg0, blk0); end
        reset_n = 1'b0; step(); reset_n = 1'b1; #1;
        n_cmp++; if ({cfg0, blk0, rdy0, pnd0} !== {7'h00, 3'b010}) begin n_fail++; $display("FAIL t6_after got %h/%b exp 00/010", cfg0, {blk0, rdy0, pnd0}); end
        n_cmp++; if (dut_word(1) !== mdl_word(1)) begin n_fail++; $display("FAIL t6_tmo got %h exp %h", dut_word(1), mdl_word(1)); end
    endtask

    task automatic test_random();
        int vs_left = 3;
        for (int c = 0; c < 3000; c++) begin
            reset_n   = ($urandom_range(0, 299) != 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_data  = 7'($urandom);
            if (vs_left == 0) begin
                VSync   = ~VSync;
                vs_left = VSync ? $urandom_range(1, 3) : $urandom_range(2, 40);
            end else begin
                vs_left--;
            end
            step();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (dut_word(k) !== mdl_word(k)) begin
                    n_fail++;
                    $display("FAIL rand_dut%0d cyc %0d got %h exp %h", k, c, dut_word(k), mdl_word(k));
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scanlines();
        test_blank();
        test_last_wins();
        test_coincident();
        test_timeout();
        test_reset_blank();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
